// File: rtl/fft_frame_feeder_if.sv
// rtl/fft_frame_feeder_if.sv - PCM sample input and FFT sink packet signals of fft_frame_feeder
interface fft_frame_feeder_if;
  logic        pcm_valid;
  logic        pcm_ready;
  logic [15:0] pcm_data;
  logic        fft_valid;
  logic        fft_ready;
  logic        fft_sop;
  logic        fft_eop;
  logic [15:0] fft_real;
  logic [15:0] fft_imag;
  logic [1:0]  fft_error;
  logic [9:0]  fft_pts;
  logic        fft_inverse;

  modport master (
    input  pcm_valid, pcm_data, fft_ready,
    output pcm_ready, fft_valid, fft_sop, fft_eop, fft_real, fft_imag,
           fft_error, fft_pts, fft_inverse
  );

  modport slave (
    output pcm_valid, pcm_data, fft_ready,
    input  pcm_ready, fft_valid, fft_sop, fft_eop, fft_real, fft_imag,
           fft_error, fft_pts, fft_inverse
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - ping-pong frame buffer turning a PCM stream into FFT sink packets
module fft_frame_feeder #(
  parameter int FFT_PTS = 512,
  parameter bit INVERSE = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  fft_frame_feeder_if.master bus
);
  localparam int AW = $clog2(FFT_PTS);
  localparam logic [AW-1:0] LAST_IDX = AW'(FFT_PTS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} rd_state_t;

  rd_state_t     state;
  rd_state_t     state_next;

  logic [15:0]   mem [2*FFT_PTS];
  logic [1:0]    full;
  logic          wr_bank;
  logic [AW-1:0] wr_idx;
  logic          rd_bank;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] rd_addr;
  logic          wr_fire;
  logic          wr_last;
  logic          rd_load;
  logic          rd_done;

  logic          fft_valid_q;
  logic          fft_sop_q;
  logic          fft_eop_q;
  logic [15:0]   fft_real_q;

  assign wr_fire = bus.pcm_valid && !full[wr_bank];
  assign wr_last = wr_fire && (wr_idx == LAST_IDX);

  assign bus.pcm_ready   = !full[wr_bank];
  assign bus.fft_valid   = fft_valid_q;
  assign bus.fft_sop     = fft_sop_q;
  assign bus.fft_eop     = fft_eop_q;
  assign bus.fft_real    = fft_real_q;
  assign bus.fft_imag    = 16'h0000;
  assign bus.fft_error   = 2'b00;
  assign bus.fft_pts     = 10'(FFT_PTS);
  assign bus.fft_inverse = INVERSE;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank, wr_idx}] <= bus.pcm_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_bank <= ~wr_bank;
        wr_idx  <= '0;
      end else begin
        wr_idx <= wr_idx + AW'(1);
      end
    end
  end

  // The writer only sets the flag of wr_bank and the reader only clears rd_bank's,
  // and the reader never owns the bank the writer is filling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 2'b00;
    end else begin
      if (wr_last) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_done) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // rd_addr looks ahead to the next sample on a transfer so the output register
  // refills on the same edge and a packet streams at one sample per cycle.
  always_comb begin
    state_next = state;
    rd_load    = 1'b0;
    rd_done    = 1'b0;
    rd_addr    = rd_idx;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        rd_load    = 1'b1;
        rd_addr    = '0;
        state_next = STREAM;
      end
      STREAM: begin
        if (bus.fft_ready) begin
          if (rd_idx == LAST_IDX) begin
            rd_done    = 1'b1;
            state_next = IDLE;
          end else begin
            rd_load = 1'b1;
            rd_addr = rd_idx + AW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output register is the synchronous RAM read port; it holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fft_valid_q <= 1'b0;
      fft_sop_q   <= 1'b0;
      fft_eop_q   <= 1'b0;
      fft_real_q  <= 16'h0000;
      rd_idx      <= '0;
      rd_bank     <= 1'b0;
    end else if (rd_load) begin
      fft_real_q  <= mem[{rd_bank, rd_addr}];
      rd_idx      <= rd_addr;
      fft_valid_q <= 1'b1;
      fft_sop_q   <= (state == FETCH);
      fft_eop_q   <= (rd_addr == LAST_IDX);
    end else if (rd_done) begin
      fft_valid_q <= 1'b0;
      fft_sop_q   <= 1'b0;
      fft_eop_q   <= 1'b0;
      rd_idx      <= '0;
      rd_bank     <= ~rd_bank;
    end
  end
endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - scoreboard bench for fft_frame_feeder with FFT_PTS = 8
module tb_fft_frame_feeder;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_n;

  fft_frame_feeder_if bus();

  fft_frame_feeder #(.FFT_PTS(N), .INVERSE(1'b0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state, owned by the monitor
  logic [15:0] exp_q[$];
  logic [15:0] exp_val;
  int held = 0, in_pos = 0, out_pos = 0, packets = 0, acc_total = 0;
  int last_eop_cyc = 0, lat_e = 0;
  bit have_eop = 0, prev_stall = 0, lat_done = 0;
  logic [15:0] prev_real;
  logic prev_sop, prev_eop;

  // driver state, owned by the stimulus process
  int acc_used = 0, feed_left = 0, next_val = 0, rmode = 0, base;
  bit rnd_data = 0, rnd_valid = 0, found;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      held = 0; in_pos = 0; out_pos = 0; have_eop = 0; prev_stall = 0;
    end else begin
      chk("pcm_ready", bus.pcm_ready, held < 2);
      if (bus.pcm_valid && bus.pcm_ready) begin
        exp_q.push_back(bus.pcm_data);
        acc_total++;
        if (in_pos == N - 1) begin
          held++;
          lat_e  = cyc + 1;
          in_pos = 0;
        end else begin
          in_pos++;
        end
      end
      if (!bus.fft_valid) chk("sop_eop_idle", {bus.fft_sop, bus.fft_eop}, 2'b00);
      if (prev_stall) begin
        chk("stall_valid", bus.fft_valid, 1'b1);
        chk("stall_real", bus.fft_real, prev_real);
        chk("stall_sop", bus.fft_sop, prev_sop);
        chk("stall_eop", bus.fft_eop, prev_eop);
      end
      if (bus.fft_valid && bus.fft_sop && !prev_stall) begin
        if (have_eop) chk("frame_gap", (cyc - last_eop_cyc) >= 3, 1'b1);
        if (!lat_done) begin
          chk("latency", cyc, lat_e + 2);
          lat_done = 1;
        end
      end
      if (bus.fft_valid && bus.fft_ready) begin
        chk("xfer_queued", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_val = exp_q.pop_front();
          chk("real", bus.fft_real, exp_val);
        end
        chk("sop", bus.fft_sop, out_pos == 0);
        chk("eop", bus.fft_eop, out_pos == N - 1);
        chk("imag", bus.fft_imag, 0);
        chk("error", bus.fft_error, 0);
        chk("pts", bus.fft_pts, N);
        chk("inverse", bus.fft_inverse, 0);
        if (out_pos == N - 1) begin
          out_pos = 0;
          held--;
          packets++;
          have_eop = 1;
          last_eop_cyc = cyc;
        end else begin
          out_pos++;
        end
      end
      prev_stall = bus.fft_valid && !bus.fft_ready;
      prev_real  = bus.fft_real;
      prev_sop   = bus.fft_sop;
      prev_eop   = bus.fft_eop;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (acc_total != acc_used) begin
      acc_used = acc_total;
      if (feed_left > 0) feed_left--;
      next_val++;
    end
    bus.pcm_valid = (feed_left > 0) && (!rnd_valid || ($urandom_range(3) != 0));
    bus.pcm_data  = rnd_data ? 16'($urandom) : 16'(next_val);
    case (rmode)
      0:       bus.fft_ready = 1'b0;
      1:       bus.fft_ready = 1'b1;
      default: bus.fft_ready = 1'($urandom_range(1));
    endcase
  endtask

  task automatic feed(input int n, input int start, input bit rd, input bit rv, input int rm);
    next_val = start; rnd_data = rd; rnd_valid = rv; rmode = rm; feed_left = n;
    for (int i = 0; i < 3000 && feed_left > 0; i++) cycle();
    chk("feed_done", feed_left, 0);
  endtask

  task automatic drain(input int rm);
    rmode = rm; feed_left = 0;
    for (int i = 0; i < 3000 && (exp_q.size() > 0 || held > 0); i++) cycle();
    chk("drained", exp_q.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, bus.fft_valid, 0);
    chk({tag, "_sop"}, bus.fft_sop, 0);
    chk({tag, "_eop"}, bus.fft_eop, 0);
    chk({tag, "_real"}, bus.fft_real, 0);
    chk({tag, "_imag"}, bus.fft_imag, 0);
    chk({tag, "_error"}, bus.fft_error, 0);
    chk({tag, "_pcm_ready"}, bus.pcm_ready, 1);
    chk({tag, "_pts"}, bus.fft_pts, N);
    chk({tag, "_inverse"}, bus.fft_inverse, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.pcm_valid = 1'b0;
    bus.pcm_data  = 16'h0000;
    bus.fft_ready = 1'b0;
    @(negedge clk);
    #1;
    check_reset_values("rst");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // single ramp frame, exact latency from last write to sop
    feed(N, 1, 0, 0, 1);
    drain(1);
    chk("latency_seen", lat_done, 1);

    // three back-to-back frames
    feed(3 * N, 1, 0, 0, 1);
    drain(1);

    // random data, random pcm_valid, random fft_ready
    feed(6 * N, 0, 1, 1, 2);
    drain(2);

    // sink stalled: exactly two frames fit before input backpressure
    base = acc_total;
    rnd_data = 0; rnd_valid = 0; rmode = 0; next_val = 1; feed_left = 1000;
    repeat (20) cycle();
    feed_left = 0;
    cycle();
    chk("accepted_while_stalled", acc_total - base, 2 * N);
    chk("pcm_ready_stalled", bus.pcm_ready, 0);
    drain(1);

    // reset while the 4th sample of a packet is on the bus
    feed(N, 1001, 0, 0, 0);
    rmode = 1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      @(negedge clk);
      #1;
      if (bus.fft_valid && bus.fft_real == 16'd1004) found = 1;
    end
    chk("reached_4th_sample", found, 1);
    reset_n = 1'b0;
    feed_left = 0;
    bus.pcm_valid = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    feed(N, 2001, 0, 0, 1);
    drain(1);

    chk("packets", packets, 13);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
